// File: rtl/rs_baud_gen.sv
// Baud-rate generator for the RS232 shifters: loadable divisor, TX bit tick, RX mid/end strobes.
// Define RS_OVS_EN to add the RX oversampling tick (rx_os_tick); otherwise it is tied low.
module rs_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 10416,
    parameter int MIN_DIV     = 3,
    parameter int OVS_LOG2    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
    input  logic             tx_ena,
    input  logic             rx_ena,
    input  logic             rx_sync,
    output logic             tx_tick,
    output logic             rx_mid,
    output logic             rx_end,
    output logic             rx_os_tick,
    output logic [DIV_W-1:0] div_q
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

    logic [DIV_W-1:0] r_tx_cnt;
    logic [DIV_W-1:0] r_rx_cnt;
    logic [DIV_W-1:0] w_div_clamped;
    logic             w_tx_tc;
    logic             w_rx_tc;
    logic             w_rx_half;
    logic             w_rx_restart;

    assign w_div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
    assign w_tx_tc       = (r_tx_cnt == div_q);
    assign w_rx_tc       = (r_rx_cnt == div_q);
    assign w_rx_half     = (r_rx_cnt == (div_q >> 1));
    // A load restarts every channel; rx_sync only restarts the RX side.
    assign w_rx_restart  = div_load || !rx_ena || rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DIV_RST;
        end else if (div_load) begin
            div_q <= w_div_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_cnt <= '0;
            tx_tick  <= 1'b0;
        end else if (div_load || !tx_ena) begin
            r_tx_cnt <= '0;
            tx_tick  <= 1'b0;
        end else begin
            tx_tick  <= w_tx_tc;
            r_tx_cnt <= w_tx_tc ? '0 : r_tx_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_cnt <= '0;
            rx_mid   <= 1'b0;
            rx_end   <= 1'b0;
        end else if (w_rx_restart) begin
            r_rx_cnt <= '0;
            rx_mid   <= 1'b0;
            rx_end   <= 1'b0;
        end else begin
            rx_mid   <= w_rx_half;
            rx_end   <= w_rx_tc;
            r_rx_cnt <= w_rx_tc ? '0 : r_rx_cnt + 1'b1;
        end
    end

`ifdef RS_OVS_EN
    logic [DIV_W:0]   w_div_p1;
    logic [DIV_W:0]   w_os_raw;
    logic [DIV_W-1:0] w_os_last;
    logic [DIV_W-1:0] r_os_cnt;
    logic             w_os_tc;

    // One extra bit so div_q+1 cannot wrap at the top of the divisor range.
    assign w_div_p1  = {1'b0, div_q} + 1'b1;
    assign w_os_raw  = w_div_p1 >> OVS_LOG2;
    assign w_os_last = (w_os_raw == '0) ? '0 : DIV_W'(w_os_raw - 1'b1);
    assign w_os_tc   = (r_os_cnt == w_os_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_os_cnt   <= '0;
            rx_os_tick <= 1'b0;
        end else if (w_rx_restart) begin
            r_os_cnt   <= '0;
            rx_os_tick <= 1'b0;
        end else begin
            rx_os_tick <= w_os_tc;
            r_os_cnt   <= w_os_tc ? '0 : r_os_cnt + 1'b1;
        end
    end
`else
    assign rx_os_tick = 1'b0;
`endif

endmodule

// File: doc/rs_baud_gen.md
Name: rs_baud_gen

Overview:
Parametrised baud-rate generator for the RS232 path, replacing the fixed-divisor single-strobe generator. It has a runtime-loadable divisor and two independent channels. The TX channel emits a bit-boundary tick. The RX channel emits a mid-bit sample strobe and a bit-end strobe, and can be re-aligned to a start-bit edge. An optional oversampling tick feeds majority-vote receivers. It sits between the system clock domain and the rs232 TX/RX shifters.

Parameters:
DIV_W, 16, width of divisor register and counters
DEFAULT_DIV, 10416, reset divisor; bit period = div_q+1 clk cycles (9600 bps at 100 MHz)
MIN_DIV, 3, smallest accepted divisor; smaller loads are clamped up to this
OVS_LOG2, 4, log2 of the oversampling ratio (only used with RS_OVS_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
div_load  input  1  1-cycle strobe: capture div_in
div_in  input  DIV_W  new divisor (bit period minus 1)
tx_ena  input  1  TX channel enable
rx_ena  input  1  RX channel enable
rx_sync  input  1  re-align RX counter (start-bit falling edge detected)
tx_tick  output  1  1-cycle pulse at each TX bit boundary
rx_mid  output  1  1-cycle pulse at RX mid-bit sample point
rx_end  output  1  1-cycle pulse at RX bit end
rx_os_tick  output  1  1-cycle oversampling pulse (0 without RS_OVS_EN)
div_q  output  DIV_W  current active divisor

Behaviour:
- Reset (rst=0, async): div_q=DEFAULT_DIV; tx_cnt=rx_cnt=os_cnt=0; all tick outputs 0. Every output is a register.
- Divisor load: on a clk edge with div_load=1, div_q <= max(div_in, MIN_DIV).
  - The same edge clears tx_cnt, rx_cnt and os_cnt to 0.
  - All tick outputs are 0 on the cycle following the load edge.
  - div_load has priority over rx_sync and over counter terminal counts.
- TX channel:
  - tx_ena=0: tx_cnt held at 0, tx_tick=0.
  - Otherwise tx_cnt counts 0..div_q and wraps to 0.
  - tx_tick is registered high for exactly one cycle when tx_cnt==div_q with tx_ena=1.
  - First tick arrives div_q+1 cycles after tx_ena rises.
- RX channel:
  - rx_ena=0: rx_cnt held at 0, all RX outputs 0.
  - Otherwise rx_cnt counts 0..div_q and wraps.
  - rx_mid=1 for one cycle when rx_cnt==(div_q>>1).
  - rx_end=1 for one cycle when rx_cnt==div_q.
- rx_sync with rx_ena=1: rx_cnt and os_cnt <= 0 on that edge. Any strobe due that edge is suppressed, so a mid-bit strobe follows (div_q>>1)+1 cycles later.
- rx_sync with rx_ena=0: ignored.
- Channels are fully independent. TX and RX pulses may coincide.
- Counter widths are DIV_W bits. Comparisons are unsigned. No overflow is possible because div_q <= 2^DIV_W-1 and the counter wraps at div_q.
- Runtime change while enabled: the new period starts from count 0 immediately; no partial-period pulse is emitted.

Optional Feature:
RS_OVS_EN.
- Defined:
  - os_div = max(1, (div_q+1)>>OVS_LOG2).
  - os_cnt counts 0..os_div-1 while rx_ena=1.
  - rx_os_tick pulses one cycle when os_cnt==os_div-1.
  - os_cnt clears on reset, on load, on rx_sync and when rx_ena=0.
- Not defined: os_cnt and its logic are absent; rx_os_tick is tied to 0.

Test Plan:
- Reset, then tx_ena=1 with DEFAULT_DIV=10416 -> tx_tick first at cycle 10417 after enable, then every 10417 cycles; rst pulled low mid-count clears all outputs asynchronously.
- div_in=9, div_load pulse, tx_ena=rx_ena=1 -> tx_tick period 10 cycles; rx_mid at rx_cnt=4 and rx_end at rx_cnt=9, 5 cycles apart; div_q reads 9.
- div_in=1 loaded -> div_q=3 (clamped); tx_tick period 4 cycles.
- div=9 running, rx_sync at rx_cnt=7 -> no rx_end at the next expected point; rx_mid 5 cycles after the sync edge; tx_tick timing unaffected.
- div_load asserted on the same edge as rx_sync and tx terminal count -> new div applied, no tick emitted that cycle, all counters 0.
- RS_OVS_EN defined, div=159, OVS_LOG2=4 -> rx_os_tick every 10 cycles (16 per bit); with div=7 the os_div is 1 and rx_os_tick is high every cycle; macro undefined -> rx_os_tick constant 0.
